// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module : i2c_master_ctrl
// Byte-level open-drain I2C master; each command runs as SCL quarter periods.
// Rev    : 1.0
// ============================================================================
module i2c_master_ctrl #(
    parameter int QDIV = 10
) (
    input  logic       pclk,
    input  logic       areset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_ack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       rsp_err,
    output logic       busy,
    output logic       scl_o,
    output logic       scl_oen,
    output logic       sda_o,
    output logic       sda_oen,
    input  logic       scl_i,
    input  logic       sda_i
);

    localparam logic [1:0]  OP_START = 2'b00;
    localparam logic [1:0]  OP_WRITE = 2'b01;
    localparam logic [1:0]  OP_READ  = 2'b10;
    localparam logic [15:0] QLAST    = 16'(QDIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOLD  = 3'd1,
        S_START = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t      r_state, w_state_n;
    logic [1:0]  r_quarter, w_quarter_n;
    logic [15:0] r_qcnt, w_qcnt_n;
    logic [3:0]  r_bit, w_bit_n;
    logic [7:0]  r_shreg, w_shreg_n;
    logic        r_ack, w_ack_n;
    logic        r_scl_oen, w_scl_oen_n;
    logic        r_sda_oen, w_sda_oen_n;
    logic        w_rsp_valid_n, w_rsp_err_n, w_rsp_nack_n, w_busy_n;
    logic [7:0]  w_rsp_data_n;
    logic        w_accept, w_stall, w_qend, w_last_bit;

    assign scl_o     = 1'b0;
    assign sda_o     = 1'b0;
    assign scl_oen   = r_scl_oen;
    assign sda_oen   = r_sda_oen;
    assign cmd_ready = (r_state == S_IDLE) || (r_state == S_HOLD);
    assign w_accept  = cmd_valid && cmd_ready;

    // A released SCL that still reads low is a slave stretching the clock.
    assign w_stall    = !r_scl_oen && !scl_i;
    assign w_qend     = (r_qcnt == QLAST);
    assign w_last_bit = ((r_state == S_WRITE) || (r_state == S_READ)) ? (r_bit == 4'd8) : 1'b1;

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            r_state   <= S_IDLE;
            r_quarter <= 2'd0;
            r_qcnt    <= 16'd0;
            r_bit     <= 4'd0;
            r_shreg   <= 8'h00;
            r_ack     <= 1'b0;
            r_scl_oen <= 1'b0;
            r_sda_oen <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_nack  <= 1'b0;
            rsp_data  <= 8'h00;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_quarter <= w_quarter_n;
            r_qcnt    <= w_qcnt_n;
            r_bit     <= w_bit_n;
            r_shreg   <= w_shreg_n;
            r_ack     <= w_ack_n;
            r_scl_oen <= w_scl_oen_n;
            r_sda_oen <= w_sda_oen_n;
            rsp_valid <= w_rsp_valid_n;
            rsp_err   <= w_rsp_err_n;
            rsp_nack  <= w_rsp_nack_n;
            rsp_data  <= w_rsp_data_n;
            busy      <= w_busy_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_quarter_n   = r_quarter;
        w_qcnt_n      = r_qcnt;
        w_bit_n       = r_bit;
        w_shreg_n     = r_shreg;
        w_ack_n       = r_ack;
        w_rsp_valid_n = 1'b0;
        w_rsp_err_n   = 1'b0;
        w_rsp_nack_n  = rsp_nack;
        w_rsp_data_n  = rsp_data;
        w_busy_n      = busy;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_op == OP_START) begin
                        w_state_n   = S_START;
                        w_quarter_n = 2'd0;
                        w_qcnt_n    = 16'd0;
                        w_bit_n     = 4'd0;
                    end else begin
                        w_rsp_valid_n = 1'b1;
                        w_rsp_err_n   = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_START: w_state_n = S_START;
                        OP_WRITE: w_state_n = S_WRITE;
                        OP_READ:  w_state_n = S_READ;
                        default:  w_state_n = S_STOP;
                    endcase
                    w_quarter_n = 2'd0;
                    w_qcnt_n    = 16'd0;
                    w_bit_n     = 4'd0;
                    w_shreg_n   = cmd_data;
                    w_ack_n     = cmd_ack;
                end
            end
            default: begin
                if (!w_stall) begin
                    if (w_qend) begin
                        w_qcnt_n    = 16'd0;
                        w_quarter_n = r_quarter + 2'd1;
                        if (r_quarter == 2'd2 && r_state == S_READ && r_bit < 4'd8)
                            w_shreg_n = {r_shreg[6:0], sda_i};
                        if (r_quarter == 2'd2 && r_state == S_WRITE && r_bit == 4'd8)
                            w_rsp_nack_n = sda_i;
                        if (r_quarter == 2'd3) begin
                            w_bit_n = r_bit + 4'd1;
                            if (w_last_bit) begin
                                w_bit_n       = 4'd0;
                                w_rsp_valid_n = 1'b1;
                                w_state_n     = S_HOLD;
                                case (r_state)
                                    S_START: w_busy_n = 1'b1;
                                    S_READ:  w_rsp_data_n = r_shreg;
                                    S_STOP: begin
                                        w_state_n = S_IDLE;
                                        w_busy_n  = 1'b0;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end else begin
                        w_qcnt_n = r_qcnt + 16'd1;
                    end
                end
            end
        endcase
    end

    // Line drive is derived from the upcoming state so it changes on the quarter boundary.
    always_comb begin
        w_scl_oen_n = r_scl_oen;
        w_sda_oen_n = r_sda_oen;
        case (w_state_n)
            S_START: begin
                case (w_quarter_n)
                    2'd0:    w_sda_oen_n = 1'b0;
                    2'd1:    w_scl_oen_n = 1'b0;
                    2'd2:    w_sda_oen_n = 1'b1;
                    default: w_scl_oen_n = 1'b1;
                endcase
            end
            S_WRITE, S_READ: begin
                case (w_quarter_n)
                    2'd0: begin
                        w_scl_oen_n = 1'b1;
                        if (w_bit_n == 4'd8)
                            w_sda_oen_n = (w_state_n == S_READ) ? !w_ack_n : 1'b0;
                        else
                            w_sda_oen_n = (w_state_n == S_WRITE) ? !w_shreg_n[3'd7 - w_bit_n[2:0]] : 1'b0;
                    end
                    2'd1, 2'd2: w_scl_oen_n = 1'b0;
                    default:    w_scl_oen_n = 1'b1;
                endcase
            end
            S_STOP: begin
                case (w_quarter_n)
                    2'd0: begin
                        w_scl_oen_n = 1'b1;
                        w_sda_oen_n = 1'b1;
                    end
                    2'd1:    w_scl_oen_n = 1'b0;
                    2'd2:    w_sda_oen_n = 1'b0;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_i2c_master_ctrl
// Directed bench for i2c_master_ctrl (QDIV=4) with a wired-AND bus and simple slave.
// Rev    : 1.0
// ============================================================================
module tb_i2c_master_ctrl;

    localparam int         QDIV     = 4;
    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    logic       pclk      = 1'b0;
    logic       areset    = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op    = 2'b00;
    logic [7:0] cmd_data  = 8'h00;
    logic       cmd_ack   = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_nack, rsp_err, busy;
    logic [7:0] rsp_data;
    logic       scl_o, scl_oen, sda_o, sda_oen;
    logic       scl_line, sda_line;
    logic       stretch = 1'b0;
    logic       slave_low;

    int          errors    = 0;
    int          checks    = 0;
    int          cyc       = 0;
    int          acc       = 0;
    int          scl_falls = 0;
    int          nrise     = 0;
    int          stop_cnt  = 0;
    logic [15:0] rise_bits = 16'h0000;
    logic        scl_prev  = 1'b1;
    logic        sda_prev  = 1'b1;
    int          sl_mode   = 0;
    int          sl_base   = 0;
    logic [7:0]  sl_byte   = 8'h00;

    assign scl_line = (scl_oen ? scl_o : 1'b1) & ~stretch;
    assign sda_line = (sda_oen ? sda_o : 1'b1) & ~slave_low;

    i2c_master_ctrl #(.QDIV(QDIV)) dut (
        .pclk      (pclk),
        .areset    (areset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_ack   (cmd_ack),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_nack  (rsp_nack),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .scl_o     (scl_o),
        .scl_oen   (scl_oen),
        .sda_o     (sda_o),
        .sda_oen   (sda_oen),
        .scl_i     (scl_line),
        .sda_i     (sda_line)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;
    always @(negedge scl_line) scl_falls <= scl_falls + 1;

    // Bus observer: SDA value at each SCL rise, and SDA rising while SCL high.
    always @(negedge pclk) begin
        if (scl_line && !scl_prev) begin
            nrise     <= nrise + 1;
            rise_bits <= {rise_bits[14:0], sda_line};
        end
        if (scl_line && scl_prev && sda_line && !sda_prev)
            stop_cnt <= stop_cnt + 1;
        scl_prev <= scl_line;
        sda_prev <= sda_line;
    end

    // Slave: mode 1 ACKs a written byte, mode 2 returns sl_byte MSB first.
    always_comb begin : slave_model
        int k;
        slave_low = 1'b0;
        k = scl_falls - sl_base;
        if (sl_mode == 1)
            slave_low = (k == 8);
        else if (sl_mode == 2 && k >= 0 && k < 8)
            slave_low = !sl_byte[3'(7 - k)];
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic ack);
        int n;
        @(negedge pclk);
        cmd_op    = op;
        cmd_data  = data;
        cmd_ack   = ack;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge pclk);
            n++;
        end
        acc = cyc;
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
    endtask

    // Waits for rsp_valid; lat is cycles after the acceptance cycle, -1 on timeout.
    task automatic run_op(input int lo, input int hi, output int lat, output int sda_cnt);
        lat = -1;
        sda_cnt = 0;
        for (int n = 0; n < 2000 && lat < 0; n++) begin
            @(negedge pclk);
            if (cyc - acc >= lo && cyc - acc <= hi && sda_oen) sda_cnt++;
            if (rsp_valid) lat = cyc - acc;
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        checks++; if ({scl_oen, sda_oen, scl_o, sda_o} !== 4'b0000) begin errors++; $display("FAIL reset_lines: got %b expected 0000", {scl_oen, sda_oen, scl_o, sda_o}); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        checks++; if ({rsp_valid, rsp_err, rsp_nack, busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {rsp_valid, rsp_err, rsp_nack, busy}); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rsp_data); end
        @(negedge pclk);
        areset = 1'b0;
    endtask

    task automatic test_reject_idle(input string tag);
        int lat, cnt;
        issue(OP_WRITE, 8'h55, 1'b0);
        run_op(1, 1, lat, cnt);
        checks++; if (lat !== 1) begin errors++; $display("FAIL %s_lat: got %0d expected 1", tag, lat); end
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL %s_err: got %b expected 1", tag, rsp_err); end
        checks++; if ({scl_oen, sda_oen, busy} !== 3'b000) begin errors++; $display("FAIL %s_bus: got %b expected 000", tag, {scl_oen, sda_oen, busy}); end
        @(negedge pclk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s_pulse: got %b expected 0", tag, rsp_valid); end
    endtask

    task automatic test_start();
        int sda_rise, scl_rise, lat;
        sda_rise = -1; scl_rise = -1; lat = -1;
        issue(OP_START, 8'h00, 1'b0);
        for (int n = 0; n < 200 && lat < 0; n++) begin
            @(negedge pclk);
            if (sda_oen && sda_rise < 0) sda_rise = cyc - acc;
            if (scl_oen && scl_rise < 0) scl_rise = cyc - acc;
            if (rsp_valid) lat = cyc - acc;
        end
        checks++; if (sda_rise !== 9) begin errors++; $display("FAIL start_sda_cycle: got %0d expected 9", sda_rise); end
        checks++; if (scl_rise !== 13) begin errors++; $display("FAIL start_scl_cycle: got %0d expected 13", scl_rise); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL start_lat: got %0d expected 17", lat); end
        checks++; if ({busy, rsp_err, cmd_ready} !== 3'b101) begin errors++; $display("FAIL start_flags: got %b expected 101", {busy, rsp_err, cmd_ready}); end
    endtask

    task automatic test_write(input logic [7:0] data, input logic slave_ack);
        int lat, cnt, nb;
        nb = nrise;
        sl_base = scl_falls;
        sl_mode = slave_ack ? 1 : 0;
        issue(OP_WRITE, data, 1'b0);
        run_op(1, 0, lat, cnt);
        sl_mode = 0;
        checks++; if (lat !== 145) begin errors++; $display("FAIL write_lat: got %0d expected 145", lat); end
        checks++; if (nrise - nb !== 9) begin errors++; $display("FAIL write_scl_pulses: got %0d expected 9", nrise - nb); end
        checks++; if (rise_bits[8:0] !== {data, ~slave_ack}) begin errors++; $display("FAIL write_bits: got %h expected %h", rise_bits[8:0], {data, ~slave_ack}); end
        checks++; if ({rsp_nack, rsp_err} !== {~slave_ack, 1'b0}) begin errors++; $display("FAIL write_nack_err: got %b expected %b", {rsp_nack, rsp_err}, {~slave_ack, 1'b0}); end
    endtask

    task automatic test_read(input logic [7:0] sbyte, input logic ack, input int exp_low, input logic exp_nack);
        int lat, cnt;
        sl_byte = sbyte;
        sl_base = scl_falls;
        sl_mode = 2;
        issue(OP_READ, 8'hFF, ack);
        run_op(1, 144, lat, cnt);
        sl_mode = 0;
        checks++; if (lat !== 145) begin errors++; $display("FAIL read_lat: got %0d expected 145", lat); end
        checks++; if (rsp_data !== sbyte) begin errors++; $display("FAIL read_data: got %h expected %h", rsp_data, sbyte); end
        checks++; if (cnt !== exp_low) begin errors++; $display("FAIL read_sda_drive: got %0d expected %0d", cnt, exp_low); end
        checks++; if ({rsp_nack, rsp_err} !== {exp_nack, 1'b0}) begin errors++; $display("FAIL read_nack_err: got %b expected %b", {rsp_nack, rsp_err}, {exp_nack, 1'b0}); end
    endtask

    task automatic test_repeated_start();
        int lat, cnt;
        issue(OP_START, 8'h00, 1'b0);
        run_op(1, 0, lat, cnt);
        checks++; if (lat !== 17) begin errors++; $display("FAIL rstart_lat: got %0d expected 17", lat); end
        checks++; if ({busy, sda_oen, scl_oen} !== 3'b111) begin errors++; $display("FAIL rstart_state: got %b expected 111", {busy, sda_oen, scl_oen}); end
    endtask

    task automatic test_stretch();
        int lat, cnt, nb;
        nb = nrise;
        sl_base = scl_falls;
        sl_mode = 1;
        issue(OP_WRITE, 8'h96, 1'b0);
        fork
            begin
                int n;
                n = 0;
                while (!(nrise - nb == 3 && scl_oen) && n < 400) begin
                    @(negedge pclk);
                    n++;
                end
                stretch = 1'b1;
                n = 0;
                while (scl_oen && n < 100) begin
                    @(posedge pclk);
                    #1;
                    n++;
                end
                repeat (10) @(posedge pclk);
                #1 stretch = 1'b0;
            end
            run_op(1, 0, lat, cnt);
        join
        sl_mode = 0;
        checks++; if (lat !== 155) begin errors++; $display("FAIL stretch_lat: got %0d expected 155", lat); end
        checks++; if (rise_bits[8:0] !== {8'h96, 1'b0}) begin errors++; $display("FAIL stretch_bits: got %h expected %h", rise_bits[8:0], {8'h96, 1'b0}); end
        checks++; if (rsp_nack !== 1'b0) begin errors++; $display("FAIL stretch_nack: got %b expected 0", rsp_nack); end
    endtask

    task automatic test_stop();
        int lat, cnt, sb;
        sb = stop_cnt;
        issue(OP_STOP, 8'h00, 1'b0);
        run_op(1, 0, lat, cnt);
        checks++; if (lat !== 17) begin errors++; $display("FAIL stop_lat: got %0d expected 17", lat); end
        checks++; if (stop_cnt - sb !== 1) begin errors++; $display("FAIL stop_condition: got %0d expected 1", stop_cnt - sb); end
        checks++; if ({busy, rsp_err, cmd_ready} !== 3'b001) begin errors++; $display("FAIL stop_flags: got %b expected 001", {busy, rsp_err, cmd_ready}); end
        checks++; if ({scl_oen, sda_oen} !== 2'b00) begin errors++; $display("FAIL stop_lines: got %b expected 00", {scl_oen, sda_oen}); end
    endtask

    task automatic test_reset_mid();
        int lat, cnt, n, seen;
        issue(OP_START, 8'h00, 1'b0);
        run_op(1, 0, lat, cnt);
        issue(OP_WRITE, 8'h00, 1'b0);
        n = 0;
        while (cyc - acc < 66 && n < 200) begin
            @(negedge pclk);
            n++;
        end
        checks++; if ({scl_oen, sda_oen} !== 2'b11) begin errors++; $display("FAIL midrst_pre: got %b expected 11", {scl_oen, sda_oen}); end
        areset = 1'b1;
        #1;
        checks++; if ({scl_oen, sda_oen} !== 2'b00) begin errors++; $display("FAIL midrst_lines: got %b expected 00", {scl_oen, sda_oen}); end
        checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL midrst_ready_busy: got %b expected 10", {cmd_ready, busy}); end
        repeat (2) @(negedge pclk);
        areset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (rsp_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_rsp: got %0d expected 0", seen); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test sequence");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reject_idle("reject_idle");
        test_start();
        test_write(8'hA5, 1'b1);
        test_write(8'h5A, 1'b0);
        test_read(8'h3C, 1'b1, 0, 1'b1);
        test_read(8'hC3, 1'b0, 16, 1'b1);
        test_repeated_start();
        test_stretch();
        test_stop();
        test_reset_mid();
        test_reject_idle("reject_after_reset");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
